// File: rtl/echo_counter.sv
// Echo pulse width meter: synchronizes the receiver echo, times each enabled
// pulse in clk cycles and holds the last completed width on distance_raw.
module echo_counter #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             echo_pulse,
   input  logic             enable_count,
   output logic [WIDTH-1:0] distance_raw
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic [SYNC_STAGES:0]   vld_pipe;
   logic                   echo_s;
   logic                   echo_d;
   logic                   rise;

   state_t                 state;
   state_t                 state_nxt;
   logic [WIDTH-1:0]       count;
   logic [WIDTH-1:0]       count_nxt;
   logic                   load;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_pipe <= '0;
         echo_d    <= 1'b0;
         vld_pipe  <= '0;
      end else begin
         sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], echo_pulse};
         echo_d    <= echo_s;
         vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      end
   end

   assign echo_s = sync_pipe[SYNC_STAGES-1];

   // The zeros flushed in by reset are not real samples: a rise only counts
   // once echo_d holds a genuine sample, so an echo still high after reset
   // (its tail) is never mistaken for a new leading edge.
   assign rise = echo_s & ~echo_d & vld_pipe[SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rise && enable_count) state_nxt = MEASURE;
         MEASURE: if (!enable_count || !echo_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Abort (enable low) wins over the falling edge and discards the count.
   always_comb begin
      count_nxt = count;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (rise && enable_count) count_nxt = {{(WIDTH-1){1'b0}}, 1'b1};
         end
         MEASURE: begin
            if (!enable_count) begin
               count_nxt = '0;
            end else if (echo_s) begin
               count_nxt = (count == CNT_MAX) ? count : count + 1'b1;
            end else begin
               load      = 1'b1;
               count_nxt = '0;
            end
         end
         default: count_nxt = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count        <= '0;
         distance_raw <= '0;
      end else begin
         count <= count_nxt;
         if (load) distance_raw <= count;
      end
   end

endmodule

// File: tb/tb_echo_counter.sv
// Bench for echo_counter: hand-timed nominal/corner sequences, a table of
// pulse vectors, and random pulses scored against a pulse-level model.
module tb_echo_counter;

   localparam int WIDTH = 16;
   localparam int MAXV  = (1 << WIDTH) - 1;

   typedef struct {
      int          width;
      int          mode;   // 0 enabled, 1 disabled, 2 enable dropped mid-pulse
      int          gap;
      logic [15:0] exp;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             echo_pulse;
   logic             enable_count;
   logic [WIDTH-1:0] distance_raw;

   int n_cmp = 0;
   int n_bad = 0;
   int model = 0;

   echo_counter #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .echo_pulse   (echo_pulse),
      .enable_count (enable_count),
      .distance_raw (distance_raw)
   );

   always #25 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: distance_raw=%0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Echo high for w clk periods, then low for gap periods (gap >= 4);
   // distance_raw is checked three edges after the fall.
   task automatic run_pulse(input string name, input int w, input int mode,
                            input int gap, input int exp);
      enable_count = (mode != 1);
      echo_pulse   = 1'b1;
      for (int i = 0; i < w; i++) begin
         if (mode == 2 && i == w / 2) enable_count = 1'b0;
         @(negedge clk);
      end
      echo_pulse   = 1'b0;
      enable_count = 1'b1;
      tick(3);
      check(name, distance_raw, exp);
      tick(gap - 3);
   endtask

   vec_t vecs[8];

   initial begin
      vecs[0] = '{100, 2, 5, 16'd200};
      vecs[1] = '{30,  0, 4, 16'd30};
      vecs[2] = '{40,  1, 6, 16'd30};
      vecs[3] = '{1,   0, 4, 16'd1};
      vecs[4] = '{2,   0, 4, 16'd2};
      vecs[5] = '{3,   0, 7, 16'd3};
      vecs[6] = '{65,  0, 4, 16'd65};
      vecs[7] = '{12,  2, 4, 16'd65};

      reset        = 1'b1;
      echo_pulse   = 1'b0;
      enable_count = 1'b0;
      tick(2);                       // t = 100 ns, two reset edges seen
      reset = 1'b0;
      check("reset_value", distance_raw, 0);

      // Nominal 10 us echo at 20 MHz
      tick(1);                       // t = 150 ns
      enable_count = 1'b1;
      echo_pulse   = 1'b1;
      tick(199);
      check("nominal_during", distance_raw, 0);
      tick(1);                       // t = 10150 ns
      echo_pulse = 1'b0;
      tick(2);
      check("nominal_latency", distance_raw, 0);
      tick(1);                       // t = 10300 ns
      check("nominal_200", distance_raw, 200);
      tick(3);

      foreach (vecs[i])
         run_pulse($sformatf("vec%0d", i), vecs[i].width, vecs[i].mode,
                   vecs[i].gap, int'(vecs[i].exp));

      // Echo already high when enable rises: ignored
      enable_count = 1'b0;
      echo_pulse   = 1'b1;
      tick(5);
      enable_count = 1'b1;
      tick(20);
      echo_pulse = 1'b0;
      tick(5);
      check("prehigh_ignored", distance_raw, 65);
      run_pulse("after_prehigh", 25, 0, 4, 25);

      // Reset mid-measurement, tail of echo must not be measured
      echo_pulse = 1'b1;
      tick(20);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("reset_mid_clear", distance_raw, 0);
      tick(20);
      echo_pulse = 1'b0;
      tick(6);
      check("reset_tail_ignored", distance_raw, 0);
      run_pulse("after_reset_10", 10, 0, 4, 10);

      // Saturation
      run_pulse("saturate", 70000, 0, 4, MAXV);
      run_pulse("after_sat", 7, 0, 4, 7);
      model = 7;

      // Random pulses scored by pulse-level model
      for (int k = 0; k < 30; k++) begin
         int w, mode, gap;
         w    = $urandom_range(100, 1);
         mode = $urandom_range(2, 0);
         gap  = $urandom_range(8, 4);
         if (mode == 0) model = (w > MAXV) ? MAXV : w;
         run_pulse($sformatf("rand%0d", k), w, mode, gap, model);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
